// File: rtl/wb_slave_mem_bridge.sv
// Wishbone B4 pipelined slave to request/grant/rvalid memory bridge.
//
// Accepts classic single beats and pipelined INCR/EOB bursts and forwards each in-range
// beat to a simple backend that grants requests and returns one in-order response per grant.
// Responses are registered, so ack/err arrive one cycle after mem_rvalid_i.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   wb_*_i               Wishbone master-side signals (adr/dat/sel/we/stb/cyc/cti/bte)
//   wb_*_o               Wishbone slave-side signals (dat/ack/err/rty/stall)
//   mem_req_o            backend request valid
//   mem_we_o             backend write enable
//   mem_addr_o           word-aligned offset into the decoded window
//   mem_wdata_o          write data
//   mem_be_o             byte enables
//   mem_gnt_i            backend accepts the request this cycle
//   mem_rvalid_i         backend response, one per grant, in order
//   mem_rdata_i          read data, valid with mem_rvalid_i
module wb_slave_mem_bridge #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [31:0] ADDR_SIZE = 32'h0001_0000,
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  input  logic [2:0]  wb_cti_i,
  input  logic [1:0]  wb_bte_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic        wb_rty_o,
  output logic        wb_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_be_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i
);

  localparam logic [3:0] MaxCnt = 4'(MAX_OUTST);

  typedef enum logic [1:0] {StIdle, StActive, StErrResp, StDrain} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [31:0] dat_q;

  logic        beat, in_range, accept, stall, mem_req, inc, dec;
  logic [32:0] off_ext;
  logic        unused_ok;

  // 33-bit offset so windows near the top of the address space cannot wrap.
  assign off_ext  = {1'b0, wb_adr_i} - {1'b0, ADDR_BASE};
  assign in_range = ({1'b0, wb_adr_i} >= {1'b0, ADDR_BASE}) && (off_ext < {1'b0, ADDR_SIZE});
  assign beat     = wb_cyc_i & wb_stb_i;

  // cti/bte do not affect addressing: every beat carries its own adr.
  assign unused_ok = ^{wb_cti_i, wb_bte_i, off_ext[32], off_ext[1:0]};

  always_comb begin
    state_d = state_q;
    stall   = 1'b1;
    mem_req = 1'b0;

    case (state_q)
      StIdle, StActive: begin
        mem_req = beat & in_range & (cnt_q < MaxCnt);
        if (!beat) begin
          stall = 1'b0;
        end else if (in_range) begin
          stall = !(mem_req & mem_gnt_i);
        end else begin
          // Out-of-range beat waits until all earlier responses are returned.
          stall = (cnt_q != 4'd0);
        end
      end
      default: ;
    endcase

    if (!rst_ni) begin
      stall   = 1'b1;
      mem_req = 1'b0;
    end

    accept = beat & !stall;
    inc    = accept & in_range;
    // Stray responses (e.g. still in flight across a reset) are not counted.
    dec    = mem_rvalid_i & (cnt_q != 4'd0);
    cnt_d  = cnt_q + {3'b0, inc} - {3'b0, dec};

    err_d = accept & !in_range;
    ack_d = wb_cyc_i & dec & (state_q != StDrain);

    case (state_q)
      StIdle: begin
        if (wb_cyc_i) state_d = err_d ? StErrResp : StActive;
      end
      StActive: begin
        if (!wb_cyc_i)  state_d = (cnt_d == 4'd0) ? StIdle : StDrain;
        else if (err_d) state_d = StErrResp;
      end
      StErrResp: begin
        state_d = wb_cyc_i ? StActive : StIdle;
      end
      StDrain: begin
        if (cnt_d == 4'd0) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      if (mem_rvalid_i) dat_q <= mem_rdata_i;
    end
  end

  assign wb_dat_o   = dat_q;
  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_rty_o   = 1'b0;
  assign wb_stall_o = stall;

  assign mem_req_o   = mem_req;
  assign mem_we_o    = wb_we_i;
  assign mem_addr_o  = {off_ext[31:2], 2'b00};
  assign mem_wdata_o = wb_dat_i;
  assign mem_be_o    = wb_sel_i;

endmodule

// File: tb/tb_wb_slave_mem_bridge.sv
module tb_wb_slave_mem_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] adr, wdat;
  logic [3:0]  sel;
  logic        we, stb, cyc;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        gnt;
  logic        rvalid = 1'b0;
  logic [31:0] rdata  = 32'd0;
  logic        use2;

  // Instance a: MAX_OUTST=4, instance b: MAX_OUTST=2. Only the selected one sees cyc/rvalid.
  logic [31:0] a_dat, b_dat, a_addr, b_addr, a_wdata, b_wdata;
  logic        a_ack, b_ack, a_err, b_err, a_rty, b_rty, a_stall, b_stall;
  logic        a_req, b_req, a_we, b_we;
  logic [3:0]  a_be, b_be;

  wb_slave_mem_bridge u_dut_a (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
    .wb_stb_i(stb & !use2), .wb_cyc_i(cyc & !use2), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(a_dat), .wb_ack_o(a_ack), .wb_err_o(a_err), .wb_rty_o(a_rty), .wb_stall_o(a_stall),
    .mem_req_o(a_req), .mem_we_o(a_we), .mem_addr_o(a_addr), .mem_wdata_o(a_wdata),
    .mem_be_o(a_be), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid & !use2), .mem_rdata_i(rdata)
  );

  wb_slave_mem_bridge #(.MAX_OUTST(2)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n),
    .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel), .wb_we_i(we),
    .wb_stb_i(stb & use2), .wb_cyc_i(cyc & use2), .wb_cti_i(cti), .wb_bte_i(bte),
    .wb_dat_o(b_dat), .wb_ack_o(b_ack), .wb_err_o(b_err), .wb_rty_o(b_rty), .wb_stall_o(b_stall),
    .mem_req_o(b_req), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_wdata),
    .mem_be_o(b_be), .mem_gnt_i(gnt), .mem_rvalid_i(rvalid & use2), .mem_rdata_i(rdata)
  );

  logic [31:0] s_dat, s_addr, s_wdata;
  logic        s_ack, s_err, s_rty, s_stall, s_req, s_we;
  logic [3:0]  s_be;
  assign s_dat   = use2 ? b_dat   : a_dat;
  assign s_ack   = use2 ? b_ack   : a_ack;
  assign s_err   = use2 ? b_err   : a_err;
  assign s_rty   = use2 ? b_rty   : a_rty;
  assign s_stall = use2 ? b_stall : a_stall;
  assign s_req   = use2 ? b_req   : a_req;
  assign s_we    = use2 ? b_we    : a_we;
  assign s_addr  = use2 ? b_addr  : a_addr;
  assign s_wdata = use2 ? b_wdata : a_wdata;
  assign s_be    = use2 ? b_be    : a_be;

  // Backend model: in-order responses, each due `lat` cycles after its grant.
  typedef struct {int due; logic [31:0] data;} rsp_t;
  rsp_t        q[$];
  logic [31:0] mem [64];
  bit          mem_loaded = 1'b0;
  int          lat = 1;
  int          cyc_n = 0;

  always @(negedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
      mem[4] = 32'hDEAD_BEEF;
      mem_loaded = 1'b1;
    end
    if (rvalid) void'(q.pop_front());
    if (s_req && gnt) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_be[b]) mem[s_addr[7:2]][8*b +: 8] = s_wdata[8*b +: 8];
        q.push_back('{due: cyc_n + lat, data: 32'd0});
      end else begin
        q.push_back('{due: cyc_n + lat, data: mem[s_addr[7:2]]});
      end
    end
  end

  always @(posedge clk) begin
    #1;
    cyc_n++;
    if (q.size() > 0 && q[0].due <= cyc_n) begin
      rvalid = 1'b1;
      rdata  = q[0].data;
    end else begin
      rvalid = 1'b0;
    end
  end

  // Bus monitor, sampled on the falling edge.
  int          n_acc, n_ack, n_err, n_both, n_badreq, outst, max_out;
  int          acc_cyc, ack_cyc, err_cyc, first_ack_cyc, first_stall;
  logic [31:0] last_addr;
  logic [31:0] ack_dat_q[$];
  logic        clr_req = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst = 0;
    end else if (clr_req) begin
      n_acc = 0; n_ack = 0; n_err = 0; n_both = 0; n_badreq = 0; max_out = outst;
      acc_cyc = 0; ack_cyc = 0; err_cyc = 0; first_ack_cyc = -1; first_stall = -1;
      last_addr = 32'd0;
      ack_dat_q.delete();
    end else begin
      if (cyc && stb && s_stall && first_stall < 0) first_stall = n_acc;
      if (cyc && stb && !s_stall) begin
        n_acc++;
        acc_cyc   = cyc_n;
        last_addr = s_addr;
        if (adr < 32'h0001_0000) outst++;
      end
      if (rvalid && outst > 0) outst--;
      if (outst > max_out) max_out = outst;
      if (s_ack) begin
        if (n_ack == 0) first_ack_cyc = cyc_n;
        n_ack++;
        ack_cyc = cyc_n;
        ack_dat_q.push_back(s_dat);
      end
      if (s_err) begin
        n_err++;
        err_cyc = cyc_n;
      end
      if (s_ack && s_err) n_both++;
      if (s_req && !(adr < 32'h0001_0000)) n_badreq++;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    clr_req = 1'b1;
    @(negedge clk);
    #1;
    clr_req = 1'b0;
  endtask

  // Present n pipelined beats at base, base+4, ...; leaves cyc high and stb low.
  task automatic do_beats(input logic [31:0] base, input int n, input logic w);
    int i = 0;
    int budget = 200;
    while (i < n && budget > 0) begin
      @(posedge clk); #1;
      cyc  = 1'b1;
      stb  = 1'b1;
      adr  = base + 32'(4 * i);
      we   = w;
      wdat = 32'hC0DE_0000 + i;
      sel  = 4'hF;
      cti  = (n == 1) ? 3'b000 : ((i == n - 1) ? 3'b111 : 3'b010);
      @(negedge clk);
      if (!s_stall) i++;
      budget--;
    end
    @(posedge clk); #1;
    stb = 1'b0;
    we  = 1'b0;
    if (i < n) check_eq("beat_timeout", i, n);
  endtask

  // Wait for n responses (ack or err), settle a few cycles, then end the bus cycle.
  task automatic wait_resp(input int n);
    int budget = 100;
    while ((n_ack + n_err) < n && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    if ((n_ack + n_err) < n) check_eq("resp_timeout", n_ack + n_err, n);
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    cyc = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;
    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'd0; wdat = 32'd0;
    sel = 4'h0; cti = 3'b000; bte = 2'b00; gnt = 1'b1; use2 = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    check_eq("rst_stall", 32'(s_stall), 1);
    check_eq("rst_ack",   32'(s_ack),   0);
    check_eq("rst_err",   32'(s_err),   0);
    check_eq("rst_rty",   32'(s_rty),   0);
    check_eq("rst_dat",   s_dat,        0);
    check_eq("rst_req",   32'(s_req),   0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_stall", 32'(s_stall), 0);

    // Single read at 0x10, 1-cycle backend
    clear_stats();
    lat = 1;
    do_beats(32'h10, 1, 1'b0);
    wait_resp(1);
    check_eq("rd_acks",    n_ack, 1);
    check_eq("rd_nostall", first_stall, 32'hFFFF_FFFF);
    check_eq("rd_latency", ack_cyc - acc_cyc, 2);
    check_eq("rd_data",    ack_dat_q[0], 32'hDEAD_BEEF);

    // Single write at 0x24, sel=0011
    clear_stats();
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h24; sel = 4'b0011; wdat = 32'h1234_ABCD;
    @(negedge clk);
    check_eq("wr_req",   32'(s_req),   1);
    check_eq("wr_stall", 32'(s_stall), 0);
    check_eq("wr_we",    32'(s_we),    1);
    check_eq("wr_addr",  s_addr,       32'h24);
    check_eq("wr_be",    32'(s_be),    32'h3);
    check_eq("wr_wdata", s_wdata,      32'h1234_ABCD);
    @(posedge clk); #1;
    stb = 1'b0; we = 1'b0;
    wait_resp(1);
    check_eq("wr_acks", n_ack, 1);

    // Read back through an unaligned address: offset is word-aligned, sel merged bytes
    clear_stats();
    do_beats(32'h26, 1, 1'b0);
    wait_resp(1);
    check_eq("rb_addr", last_addr, 32'h24);
    check_eq("rb_data", ack_dat_q[0], 32'h1000_ABCD);

    // 4-beat INCR/EOB burst, always-granting 1-cycle backend
    clear_stats();
    do_beats(32'h40, 4, 1'b0);
    wait_resp(4);
    check_eq("burst_acks",   n_ack, 4);
    check_eq("burst_b2b",    ack_cyc - first_ack_cyc, 3);
    check_eq("burst_d0",     ack_dat_q[0], 32'h1000_0010);
    check_eq("burst_d1",     ack_dat_q[1], 32'h1000_0011);
    check_eq("burst_d2",     ack_dat_q[2], 32'h1000_0012);
    check_eq("burst_d3",     ack_dat_q[3], 32'h1000_0013);
    check_eq("burst_outst",  32'(max_out <= 2), 1);
    check_eq("burst_noerr",  n_err, 0);

    // MAX_OUTST=2 instance, 5-cycle backend
    use2 = 1'b1;
    clear_stats();
    lat = 5;
    do_beats(32'h40, 4, 1'b0);
    wait_resp(4);
    check_eq("mo2_acks",   n_ack, 4);
    check_eq("mo2_stall",  first_stall, 2);
    check_eq("mo2_outst",  max_out, 2);
    check_eq("mo2_d3",     ack_dat_q[3], 32'h1000_0013);
    use2 = 1'b0;

    // Out-of-range beat behind one pending read
    clear_stats();
    lat = 3;
    do_beats(32'h10, 1, 1'b0);
    do_beats(32'h0001_0000, 1, 1'b0);
    wait_resp(2);
    check_eq("oor_acks",   n_ack, 1);
    check_eq("oor_errs",   n_err, 1);
    check_eq("oor_order",  err_cyc - ack_cyc, 1);
    check_eq("oor_noreq",  n_badreq, 0);
    check_eq("oor_both",   n_both, 0);
    check_eq("oor_data",   ack_dat_q[0], 32'hDEAD_BEEF);

    // cyc dropped with 3 outstanding, reset pulsed during drain
    clear_stats();
    lat = 10;
    do_beats(32'h40, 3, 1'b0);
    @(posedge clk); #1;
    cyc = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("drain_noack", n_ack + n_err, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check_eq("drain_rst_stall", 32'(s_stall), 1);
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc = 1'b1;
    budget = 50;
    while (q.size() > 0 && budget > 0) begin
      @(negedge clk); #1;
      budget--;
    end
    check_eq("late_drained", q.size(), 0);
    @(negedge clk);
    check_eq("late_noack",   n_ack + n_err, 0);
    check_eq("post_stall",   32'(s_stall), 0);
    @(posedge clk); #1;
    cyc = 1'b0;
    lat = 1;
    do_beats(32'h10, 1, 1'b0);
    wait_resp(1);
    check_eq("post_acks", n_ack, 1);
    check_eq("post_data", ack_dat_q[0], 32'hDEAD_BEEF);
    check_eq("post_both", n_both, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_slave_mem_bridge.md
Name: wb_slave_mem_bridge

Overview:
- Wishbone B4 pipelined slave (responder) that turns bus cycles into a simple request/grant/rvalid memory-side interface for on-chip SRAM or a peripheral register file.
- Sits on a slave port of the Wishbone interconnect, facing the core-side Wishbone master bridge.
- Serves classic single beats and the 4-beat INCR/EOB bursts used for cache line fills and writebacks.
- Responds in order; stalls when the backend or its outstanding-response tracking is full.

Parameters:
- ADDR_BASE, 32'h0000_0000, byte base address of the decoded window.
- ADDR_SIZE, 32'h0001_0000, window size in bytes; power of two.
- MAX_OUTST, 4, maximum accepted-but-unacknowledged beats; range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- wb_m_i  in  wb_master_t  adr/dat/sel/we/stb/cyc/cti/bte from the interconnect.
- wb_s_o  out  wb_slave_t  dat/ack/err/rty/stall to the interconnect.
- mem_req_o  out  1  backend request valid.
- mem_we_o  out  1  backend write enable.
- mem_addr_o  out  WB_ADDR_WIDTH  word-aligned offset (adr - ADDR_BASE, bits [1:0] forced 0).
- mem_wdata_o  out  WB_DATA_WIDTH  write data.
- mem_be_o  out  WB_SEL_WIDTH  byte enables (= sel).
- mem_gnt_i  in  1  backend accepts the request this cycle.
- mem_rvalid_i  in  1  backend response, one per granted request, in order (write or read).
- mem_rdata_i  in  WB_DATA_WIDTH  read data, valid with mem_rvalid_i.

Behaviour:
- Reset values (async assert, sync release): state=IDLE, outst_cnt=0, ack=0, err=0, rty=0, dat=0, mem_req_o=0.
- wb_s_o.stall is high during reset.
- Beat accepted when cyc & stb & !stall.
- in_range = (adr >= ADDR_BASE) && (adr - ADDR_BASE < ADDR_SIZE); computed in 33-bit arithmetic, so no wrap at 2^32.
- mem_req_o = cyc & stb & in_range & (outst_cnt < MAX_OUTST) & state==ACTIVE/IDLE. All mem_* fields are combinational passthroughs of wb_m_i.
- stall = !(mem_req_o & mem_gnt_i) for in-range beats.
- rty is tied to 0.
- Response path is registered. ack <= cyc & mem_rvalid_i; dat <= mem_rdata_i when mem_rvalid_i, otherwise dat holds. Latency is exactly 1 cycle after mem_rvalid_i, so a minimum 2-cycle stb-to-ack.
- outst_cnt: +1 on accept, -1 on mem_rvalid_i, net 0 when both occur. Never exceeds MAX_OUTST; stall prevents overflow.
- Full pipelining: with an always-granting, 1-cycle backend, a 4-beat burst gives 4 back-to-back acks.
- cti/bte are ignored for addressing; the slave uses adr per beat. An EOB beat is served like any other beat.
- States:
  - IDLE: no cycle. cyc -> ACTIVE, and the first beat can be accepted in the same cycle.
  - ACTIVE: normal serving.
    - Out-of-range stb: stall until outst_cnt==0, then accept without forwarding to the backend -> ERR_RESP.
    - cyc falls with outst_cnt>0 -> DRAIN.
    - cyc falls with outst_cnt==0 -> IDLE.
  - ERR_RESP: err=1 for exactly one cycle (ack=0), stall=1, -> ACTIVE if cyc else IDLE.
  - DRAIN: stall=1, mem_req_o=0. mem_rvalid_i responses are consumed with no ack/err. When outst_cnt reaches 0 -> IDLE.
- Simultaneous events:
  - Accept and response in the same cycle: the counter is unchanged.
  - cyc drop in the same cycle as the last rvalid: go straight to IDLE; no ack is emitted because cyc=0.
  - A new cyc while in DRAIN is stalled until the state returns to IDLE.
- Reset mid-operation: all state clears immediately. Backend responses still in flight after reset are ignored while outst_cnt==0; mem_rvalid_i with outst_cnt==0 is never acked.
- ack and err are never high together; at most one response per accepted beat.

Test Plan:
- Single read, ADDR_BASE=0, adr=0x10, backend rvalid 1 cycle after gnt with rdata=0xDEADBEEF -> one ack 2 cycles after stb, dat=0xDEADBEEF, stall=0 in the accept cycle.
- Single write, adr=0x24, sel=4'b0011, dat=0x1234ABCD -> mem_we_o=1, mem_addr_o=0x24, mem_be_o=0011, mem_wdata_o=0x1234ABCD; one ack.
- 4-beat INCR/EOB read burst 0x40..0x4C, always-gnt backend -> 4 consecutive acks with in-order data, outst_cnt peaks at ≤2, returns to IDLE.
- MAX_OUTST=2, backend rvalid delayed 5 cycles, 4 pipelined stbs -> stall asserted after 2 accepts; total 4 acks, never more than 2 outstanding.
- Out-of-range adr=ADDR_BASE+ADDR_SIZE issued behind 1 pending read -> stalled until that read acks, then a one-cycle err, no mem_req_o.
- cyc dropped with 3 outstanding, then async reset pulsed during DRAIN -> no ack/err after cyc drop; after reset stall=0 and outst_cnt=0 with late rvalid ignored; a new read completes normally.
